// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: pattern mode encoding and
// the per-mode initial pattern rule.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BINARY = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   // Chase and bounce start as a single lit LED at bit 0; binary and blink start dark.
   function automatic logic init_lsb(input mode_e m);
      return (m == MODE_CHASE) || (m == MODE_BOUNCE);
   endfunction

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// Enabled modulo-DIV counter producing a strobe on the enabled cycle that
// completes each count, so the consumer can act on that same edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the count this cycle
//   clr        : restart the count at 0 (overrides en, suppresses tick)
//   tick       : combinational strobe, high when an enabled cycle wraps the count
module tick_divider
   import led_pkg::*;
#(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   // DIV==1 keeps a single bit that never leaves 0, so every enabled cycle ticks.
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic          at_last;

   assign at_last = (cnt == LAST);
   assign tick    = en & ~clr & at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_last ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// Board-level LED driver: steps an N_LEDS pattern (binary, chase, bounce,
// blink) every TICK_DIV cycles and breathes the green LED with a
// triangle-wave PWM duty.
// Ports:
//   clk, rst_n : 12 MHz clock, asynchronous active-low reset
//   mode       : pattern select (0 binary, 1 chase, 2 bounce, 3 blink)
//   pause      : freezes every counter and holds all outputs
//   led        : registered pattern LEDs
//   green      : registered breathing PWM output
//   tick       : registered one-cycle pulse on each pattern step
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int unsigned N_LEDS       = 4,
   parameter int unsigned TICK_DIV     = 1200000,
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned BREATH_SHIFT = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode,
   input  logic              pause,
   output logic [N_LEDS-1:0] led,
   output logic              green,
   output logic              tick
);

   localparam int unsigned        BREATH_DIV = 32'd1 << BREATH_SHIFT;
   localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

   mode_e               mode_q;
   logic                mode_chg;
   logic                step;
   logic                bounce_up;
   logic                bounce_up_nxt;
   logic [N_LEDS-1:0]   led_nxt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty;
   logic                duty_up;
   logic                pwm_wrap;
   logic                breath_step;

   // A mode change restarts the prescaler and takes priority over a step.
   assign mode_chg = (mode_e'(mode) != mode_q);

   tick_divider #(.DIV(TICK_DIV)) u_step_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~pause),
      .clr   (mode_chg),
      .tick  (step)
   );

   // Next pattern: reload on mode change, otherwise advance on a step.
   always_comb begin
      led_nxt       = led;
      bounce_up_nxt = bounce_up;
      if (mode_chg) begin
         led_nxt       = N_LEDS'(init_lsb(mode_e'(mode)));
         bounce_up_nxt = 1'b1;
      end else if (step) begin
         case (mode_q)
            MODE_BINARY: led_nxt = led + N_LEDS'(1);
            MODE_CHASE:  led_nxt = (led << 1) | (led >> (N_LEDS - 1));
            MODE_BOUNCE: begin
               // Direction flips on arrival at an end, so each end shows for one step.
               if (N_LEDS > 1) begin
                  if (bounce_up) begin
                     led_nxt = led << 1;
                     if (led_nxt[N_LEDS-1]) bounce_up_nxt = 1'b0;
                  end else begin
                     led_nxt = led >> 1;
                     if (led_nxt[0]) bounce_up_nxt = 1'b1;
                  end
               end
            end
            MODE_BLINK:  led_nxt = ~led;
            default:     led_nxt = led;
         endcase
      end
   end

   // Pattern state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_BINARY;
         led       <= '0;
         bounce_up <= 1'b1;
         tick      <= 1'b0;
      end else begin
         mode_q    <= mode_e'(mode);
         led       <= led_nxt;
         bounce_up <= bounce_up_nxt;
         tick      <= step;
      end
   end

   assign pwm_wrap = ~pause & (pwm_cnt == PWM_MAX);

   tick_divider #(.DIV(BREATH_DIV)) u_breath_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pwm_wrap),
      .clr   (1'b0),
      .tick  (breath_step)
   );

   // PWM counter/output and triangle-wave duty; duty turns at the ends with no plateau.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         green   <= 1'b0;
         duty    <= '0;
         duty_up <= 1'b1;
      end else begin
         if (!pause) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            green   <= (pwm_cnt < duty);
         end
         if (breath_step) begin
            if (duty_up) begin
               if (duty == PWM_MAX) begin
                  duty    <= duty - PWM_BITS'(1);
                  duty_up <= 1'b0;
               end else begin
                  duty <= duty + PWM_BITS'(1);
               end
            end else begin
               if (duty == '0) begin
                  duty    <= PWM_BITS'(1);
                  duty_up <= 1'b1;
               end else begin
                  duty <= duty - PWM_BITS'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (N_LEDS=4, TICK_DIV=4, PWM_BITS=3,
// BREATH_SHIFT=0): constant-vector table, PWM/reset sequences, and a random
// run against a step-count based reference model.
module tb_led_pattern_gen;

   localparam int unsigned N  = 4;
   localparam int unsigned TD = 4;
   localparam int unsigned PB = 3;
   localparam int unsigned BS = 0;
   localparam int unsigned PWM_PERIOD = 1 << PB;
   localparam int unsigned DMAX       = PWM_PERIOD - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   mode;
   logic         pause;
   logic [N-1:0] led;
   logic         green;
   logic         tick;

   always #5 clk = ~clk;

   led_pattern_gen #(
      .N_LEDS       (N),
      .TICK_DIV     (TD),
      .PWM_BITS     (PB),
      .BREATH_SHIFT (BS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode),
      .pause (pause),
      .led   (led),
      .green (green),
      .tick  (tick)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: steps since the last pattern load, prescaler phase,
   // and non-paused cycles since reset for the PWM.
   int m_mode, m_cnt, m_k, m_t;
   logic m_tick, m_green;

   function automatic int tri_wave(input int p);
      int q;
      q = p % (2 * DMAX);
      return (q <= DMAX) ? q : 2 * DMAX - q;
   endfunction

   function automatic logic [N-1:0] exp_led(input int md, input int k);
      int p, pos;
      case (md)
         0: return N'(k % (1 << N));
         1: return N'(1 << (k % N));
         2: begin
            p   = k % (2 * (N - 1));
            pos = (p < N) ? p : 2 * (N - 1) - p;
            return N'(1 << pos);
         end
         default: return (k % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_k = 0; m_t = 0;
      m_tick = 1'b0; m_green = 1'b0;
   endtask

   task automatic model_edge(input int md, input logic ps);
      m_tick = 1'b0;
      if (md != m_mode) begin
         m_mode = md; m_cnt = 0; m_k = 0;
      end else if (!ps) begin
         if (m_cnt == TD - 1) begin
            m_cnt = 0; m_k++; m_tick = 1'b1;
         end else begin
            m_cnt++;
         end
      end
      if (!ps) begin
         m_green = ((m_t % PWM_PERIOD) < tri_wave((m_t / PWM_PERIOD) >> BS));
         m_t++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("model_led", 32'(led), 32'(exp_led(m_mode, m_k)));
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_green", 32'(green), 32'(m_green));
   endtask

   // Apply inputs for one clock edge, update the model, sample 1 ns later.
   task automatic cyc(input logic [1:0] md, input logic ps);
      mode  = md;
      pause = ps;
      @(posedge clk);
      model_edge(int'(md), ps);
      #1;
   endtask

   typedef struct {
      logic [1:0]   md;
      logic         ps;
      int           n;
      logic [N-1:0] led;
      logic         tk;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] md, input logic ps, input int n,
                      input logic [N-1:0] l, input logic tk);
      vec_t v;
      v.md = md; v.ps = ps; v.n = n; v.led = l; v.tk = tk;
      tbl.push_back(v);
   endtask

   int duty_tab[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

   initial begin
      int hi;
      logic [1:0] rmd;
      logic rps;

      rst_n = 1'b0; mode = 2'd0; pause = 1'b0;
      model_reset();
      #12;
      chk("reset_led", 32'(led), 32'h0);
      chk("reset_green", 32'(green), 32'h0);
      chk("reset_tick", 32'(tick), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // Breathing: high count per 8-cycle period follows the triangle table.
      for (int p = 0; p < 16; p++) begin
         hi = 0;
         for (int c = 0; c < 8; c++) begin
            cyc(2'd0, 1'b0);
            chk_model();
            hi += int'(green);
         end
         chk("pwm_high_count", 32'(hi), 32'(duty_tab[p]));
      end
      for (int c = 0; c < 10; c++) begin
         cyc(2'd0, 1'b0);
         chk_model();
      end
      chk("pre_reset_green", 32'(green), 32'h1);
      chk("pre_reset_led", 32'(led), 32'h2);

      // Asynchronous reset between clock edges.
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_led", 32'(led), 32'h0);
      chk("async_reset_green", 32'(green), 32'h0);
      chk("async_reset_tick", 32'(tick), 32'h0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;

      // Constant vectors: {mode, pause, cycles, expected led, expected tick}.
      add(0, 0, 3, 4'b0000, 0);  add(0, 0, 1, 4'b0001, 1);
      add(0, 0, 1, 4'b0001, 0);  add(0, 0, 3, 4'b0010, 1);
      add(0, 0, 55, 4'b1111, 0); add(0, 0, 1, 4'b0000, 1);
      add(1, 0, 1, 4'b0001, 0);  add(1, 0, 3, 4'b0001, 0);
      add(1, 0, 1, 4'b0010, 1);  add(1, 0, 4, 4'b0100, 1);
      add(1, 0, 4, 4'b1000, 1);  add(1, 0, 4, 4'b0001, 1);
      add(2, 0, 1, 4'b0001, 0);  add(2, 0, 4, 4'b0010, 1);
      add(2, 0, 4, 4'b0100, 1);  add(2, 0, 4, 4'b1000, 1);
      add(2, 0, 4, 4'b0100, 1);  add(2, 0, 4, 4'b0010, 1);
      add(2, 0, 4, 4'b0001, 1);  add(2, 0, 4, 4'b0010, 1);
      add(3, 0, 1, 4'b0000, 0);  add(3, 0, 4, 4'b1111, 1);
      add(3, 0, 4, 4'b0000, 1);  add(3, 0, 2, 4'b0000, 0);
      add(1, 0, 1, 4'b0001, 0);  add(1, 0, 3, 4'b0001, 0);
      add(1, 0, 1, 4'b0010, 1);
      add(1, 0, 2, 4'b0010, 0);  add(1, 1, 10, 4'b0010, 0);
      add(1, 0, 1, 4'b0010, 0);  add(1, 0, 1, 4'b0100, 1);
      add(2, 1, 1, 4'b0001, 0);  add(2, 1, 3, 4'b0001, 0);
      add(2, 0, 3, 4'b0001, 0);  add(2, 0, 1, 4'b0010, 1);

      foreach (tbl[i]) begin
         for (int c = 0; c < tbl[i].n; c++) cyc(tbl[i].md, tbl[i].ps);
         chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
         chk($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].tk));
         chk($sformatf("tbl%0d_green", i), 32'(green), 32'(m_green));
      end

      // Random mode changes and pauses against the reference model.
      rmd = 2'd2;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) rmd = 2'($urandom_range(0, 3));
         rps = ($urandom_range(0, 4) == 0);
         cyc(rmd, rps);
         chk_model();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
